ps2_rx_byte: RTL and testbench

- Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins.
- Each frame is 11 bits: start, 8 data bits LSB first, odd parity, stop.
- Delivers each validated scan-code byte with a one-cycle strobe.
- Sits directly upstream of the 3-deep scan-code shift register: data_out drives its data_in, and data_valid drives its enable, so break-code (0xF0) detection downstream sees exactly one shift per received byte.

---
 rtl/ps2_rx_byte.sv | 150 +++++++++++++++
 tb/tb_ps2_rx_byte.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_byte.sv
// PS/2 frame receiver: synchronizes and de-glitches the raw pins, decodes
// start/8 data/odd parity/stop frames and strobes out each good byte.
module ps2_rx_byte #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int            TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]    FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          s1_clk, s2_clk, s1_data, s2_data;
  logic          filt_clk, filt_clk_d;
  logic [7:0]    filt_cnt;
  logic          fall;

  state_t        state, state_d;
  logic [7:0]    shreg, shreg_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic          par_ok, par_ok_d;
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic [7:0]    data_out_d;
  logic          data_valid_d, parity_err_d, frame_err_d;

  // NOTE: every flop below uses non-blocking assignment so all registers
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_clk  <= 1'b1;
      s2_clk  <= 1'b1;
      s1_data <= 1'b1;
      s2_data <= 1'b1;
    end else begin
      s1_clk  <= ps2_clk;
      s2_clk  <= s1_clk;
      s1_data <= ps2_data;
      s2_data <= s1_data;
    end
  end

  // filt_clk only follows s2_clk after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= 8'd0;
    end else begin
      filt_clk_d <= filt_clk;
      if (s2_clk == filt_clk) begin
        filt_cnt <= 8'd0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= s2_clk;
        filt_cnt <= 8'd0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  assign fall = filt_clk_d & ~filt_clk;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    shreg_d      = shreg;
    bit_cnt_d    = bit_cnt;
    par_ok_d     = par_ok;
    data_out_d   = data_out;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_cnt_d    = (fall || state == IDLE) ? '0 : tmo_cnt + 1'b1;

    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!s2_data) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shreg_d   = {s2_data, shreg[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^shreg ^ s2_data;
          state_d  = STOP;
        end
        STOP: begin
          // A bad stop bit reports only as a framing error, whatever the parity.
          if (!s2_data) begin
            frame_err_d = 1'b1;
          end else if (par_ok) begin
            data_out_d   = shreg;
            data_valid_d = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_MAX) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      shreg      <= 8'd0;
      bit_cnt    <= 3'd0;
      par_ok     <= 1'b0;
      tmo_cnt    <= '0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      busy       <= (state_d != IDLE);
      shreg      <= shreg_d;
      bit_cnt    <= bit_cnt_d;
      par_ok     <= par_ok_d;
      tmo_cnt    <= tmo_cnt_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_rx_byte.sv
// Self-checking bench for ps2_rx_byte: drives PS/2 frames on the raw pins and
// compares every cycle against a frame-level event model.
module tb_ps2_rx_byte;

  localparam int F    = 8;
  localparam int T    = 2000;
  localparam int HALF = 100;
  localparam int LAT  = F + 3;  // pin fall to registered effect

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;

  ps2_rx_byte #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef enum {EV_VALID, EV_PERR, EV_FERR} ev_kind_t;
  typedef struct {
    int       at;
    ev_kind_t kind;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] model_data = 8'h00;
  int         busy_lo = 0;
  int         busy_hi = 0;
  int         rst_at = 1;
  int         last_fall = 0;

  int         n_valid = 0, n_perr = 0, n_ferr = 0;
  int         last_valid_cyc = 0, last_ferr_cyc = 0;
  logic [7:0] seen[$];

  logic exp_v, exp_p, exp_f;
  ev_t  cur;

  // Expected outputs come from the event queue filled by the frame drivers.
  always @(negedge clock) begin
    exp_v = 1'b0;
    exp_p = 1'b0;
    exp_f = 1'b0;
    if (cyc == rst_at) model_data = 8'h00;
    if (evq.size() > 0 && evq[0].at == cyc) begin
      cur = evq.pop_front();
      case (cur.kind)
        EV_VALID: begin exp_v = 1'b1; model_data = cur.b; end
        EV_PERR:  exp_p = 1'b1;
        default:  exp_f = 1'b1;
      endcase
    end
    check("data_valid", {31'd0, data_valid}, {31'd0, exp_v});
    check("parity_err", {31'd0, parity_err}, {31'd0, exp_p});
    check("frame_err",  {31'd0, frame_err},  {31'd0, exp_f});
    check("data_out",   {24'd0, data_out},   {24'd0, model_data});
    check("busy",       {31'd0, busy},       {31'd0, (cyc >= busy_lo && cyc < busy_hi)});
    if (data_valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
      seen.push_back(data_out);
    end
    if (parity_err === 1'b1) n_perr++;
    if (frame_err === 1'b1) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bit_fall(input logic b);
    ps2_data = b;
    wait_cycles(HALF / 2);
    ps2_clk   = 1'b0;
    last_fall = cyc + LAT;
  endtask

  task automatic bit_rise();
    wait_cycles(HALF);
    ps2_clk = 1'b1;
    wait_cycles(HALF / 2);
  endtask

  task automatic start_bit();
    bit_fall(1'b0);
    busy_lo = last_fall;
    busy_hi = 32'h7fff_ffff;
    bit_rise();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic     par;
    ev_kind_t k;
    par = ~(^b) ^ bad_par;
    start_bit();
    for (int i = 0; i < 8; i++) begin
      bit_fall(b[i]);
      bit_rise();
    end
    bit_fall(par);
    bit_rise();
    bit_fall(~bad_stop);
    if (bad_stop)     k = EV_FERR;
    else if (bad_par) k = EV_PERR;
    else              k = EV_VALID;
    evq.push_back('{last_fall, k, b});
    busy_hi = last_fall;
    bit_rise();
    ps2_data = 1'b1;
  endtask

  int stop_drive;
  int data_drive;

  initial begin
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(20);

    // Clean 0x1C
    send_frame(8'h1C, 1'b0, 1'b0);
    stop_drive = last_fall - LAT;
    wait_cycles(30);
    check("lit_data_1c", {24'd0, data_out}, 32'h1C);
    check("lit_valid_count_1", n_valid, 1);
    check("lit_latency", last_valid_cyc - stop_drive, 11);
    check("lit_busy_idle", {31'd0, busy}, 0);

    // Back-to-back 0xF0 then 0x1C
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_cycles(30);
    check("lit_valid_count_3", n_valid, 3);
    check("lit_seen_f0", {24'd0, seen[1]}, 32'hF0);
    check("lit_seen_1c", {24'd0, seen[2]}, 32'h1C);

    // 0xF0 then 0x1C with a flipped parity bit
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    wait_cycles(30);
    check("lit_perr_count", n_perr, 1);
    check("lit_data_kept_f0", {24'd0, data_out}, 32'hF0);
    check("lit_valid_count_4", n_valid, 4);

    // 0x5A with stop bit 0
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_cycles(30);
    check("lit_ferr_count_1", n_ferr, 1);
    check("lit_perr_still_1", n_perr, 1);
    check("lit_valid_count_4b", n_valid, 4);

    // Start plus 3 data bits, then silence until the timeout fires
    start_bit();
    for (int i = 0; i < 3; i++) begin
      bit_fall(1'($urandom_range(0, 1)));
      if (i == 2) begin
        data_drive = last_fall - LAT;
        evq.push_back('{last_fall + T, EV_FERR, 8'h00});
        busy_hi = last_fall + T;
      end
      bit_rise();
    end
    ps2_data = 1'b1;
    wait_cycles(T + 50);
    check("lit_ferr_count_2", n_ferr, 2);
    check("lit_timeout_delay", last_ferr_cyc - data_drive, LAT + T);
    check("lit_busy_after_timeout", {31'd0, busy}, 0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_cycles(30);
    check("lit_data_after_timeout", {24'd0, data_out}, 32'h1C);

    // Short glitch on ps2_clk while idle
    ps2_clk = 1'b0;
    wait_cycles(5);
    ps2_clk = 1'b1;
    wait_cycles(40);
    check("lit_busy_after_glitch", {31'd0, busy}, 0);

    // Reset in the middle of a frame
    start_bit();
    for (int i = 0; i < 4; i++) begin
      bit_fall(1'($urandom_range(0, 1)));
      bit_rise();
    end
    reset   = 1'b1;
    rst_at  = cyc + 1;
    busy_hi = cyc + 1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(20);
    check("lit_busy_after_reset", {31'd0, busy}, 0);
    check("lit_data_after_reset", {24'd0, data_out}, 0);
    send_frame(8'h29, 1'b0, 1'b0);
    wait_cycles(30);
    check("lit_data_29", {24'd0, data_out}, 32'h29);

    // Random frames, occasional parity or stop corruption, random gaps
    for (int n = 0; n < 12; n++) begin
      send_frame(8'($urandom_range(0, 255)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) wait_cycles($urandom_range(1, 300));
    end
    wait_cycles(50);
    check("events_drained", evq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
